// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/VALID handshake between instruction memory and the IR.
// Optional memory-stall counter enabled by defining FETCH_STALL_CNT_EN.
`timescale 1ns/1ps
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run_i,
   input  logic        redirect_i,
   input  logic [15:0] redirect_pc_i,
   output logic        mem_req_o,
   output logic [15:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [15:0] mem_rdata_i,
   output logic [15:0] instr_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [15:0] pc_o,
   output logic [15:0] stall_cnt_o
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] instr_q, instr_d;
   logic          req_q, req_d;
   logic          valid_q, valid_d;

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         req_q   <= req_d;
         valid_q <= valid_d;
      end
   end

   // Next state; redirect outranks ack and transfer in every state
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         IDLE: begin
            if (redirect_i) begin
               pc_d = redirect_pc_i;
            end else if (run_i) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (redirect_i) begin
               pc_d = redirect_pc_i;
            end else if (mem_ack_i) begin
               instr_d = mem_rdata_i;
               pc_d    = pc_q + AW'(1);
               state_d = VALID;
            end
         end
         VALID: begin
            if (redirect_i) begin
               pc_d    = redirect_pc_i;
               state_d = REQ;
            end else if (instr_ready_i) begin
               state_d = run_i ? REQ : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_d   = (state_d == REQ);
      valid_d = (state_d == VALID);
   end

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_q;

   // Saturating count of REQ cycles without ack
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else if ((state_q == REQ) && !mem_ack_i && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = 16'h0000;
`endif

   assign mem_req_o     = req_q;
   assign mem_addr_o    = pc_q;
   assign pc_o          = pc_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model compared every cycle.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam logic [15:0] RPC = 16'h0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        run_i, redirect_i, mem_ack_i, instr_ready_i;
   logic [15:0] redirect_pc_i, mem_rdata_i;
   logic        mem_req_o, instr_valid_o;
   logic [15:0] mem_addr_o, instr_o, pc_o, stall_cnt_o;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .run_i(run_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .instr_o(instr_o),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .pc_o(pc_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an outstanding request flag, a one-entry buffer and the PC
   logic        m_busy, m_full;
   logic [15:0] m_pc, m_buf, m_stall;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 1'b0; m_full = 1'b0; m_pc = RPC; m_buf = 16'h0; m_stall = 16'h0;
      end else begin
         automatic logic was_busy = m_busy;
         automatic logic was_full = m_full;
`ifdef FETCH_STALL_CNT_EN
         if (was_busy && !mem_ack_i && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
         if (redirect_i) begin
            m_pc   = redirect_pc_i;
            m_full = 1'b0;
            m_busy = was_busy || was_full;
         end else if (was_busy) begin
            if (mem_ack_i) begin
               m_buf = mem_rdata_i; m_pc = m_pc + 16'd1; m_busy = 1'b0; m_full = 1'b1;
            end
         end else if (was_full) begin
            if (instr_ready_i) begin
               m_full = 1'b0; m_busy = run_i;
            end
         end else if (run_i) begin
            m_busy = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("cyc_req",   {15'd0, mem_req_o},     {15'd0, m_busy});
      chk("cyc_valid", {15'd0, instr_valid_o}, {15'd0, m_full});
      chk("cyc_addr",  mem_addr_o, m_pc);
      chk("cyc_pc",    pc_o, m_pc);
      chk("cyc_stall", stall_cnt_o, m_stall);
      if (m_full) chk("cyc_instr", instr_o, m_buf);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [15:0] EXP_STALL3 =
`ifdef FETCH_STALL_CNT_EN
      16'd3;
`else
      16'd0;
`endif

   initial begin
      reset = 1'b0; run_i = 0; redirect_i = 0; mem_ack_i = 0; instr_ready_i = 0;
      redirect_pc_i = 16'h0; mem_rdata_i = 16'h0;
      step(); step();
      chk("rst_req",   {15'd0, mem_req_o}, 16'd0);
      chk("rst_valid", {15'd0, instr_valid_o}, 16'd0);
      chk("rst_pc",    pc_o, 16'h0000);
      chk("rst_instr", instr_o, 16'h0000);
      chk("rst_stall", stall_cnt_o, 16'h0000);

      // First fetch, acked in the request cycle
      reset = 1'b1; run_i = 1'b1;
      step();
      chk("f1_req",  {15'd0, mem_req_o}, 16'd1);
      chk("f1_addr", mem_addr_o, 16'h0000);
      mem_ack_i = 1'b1; mem_rdata_i = 16'hA5A5;
      step();
      mem_ack_i = 1'b0;
      chk("f1_valid", {15'd0, instr_valid_o}, 16'd1);
      chk("f1_instr", instr_o, 16'hA5A5);
      chk("f1_pc",    pc_o, 16'h0001);

      // Downstream back-pressure holds the buffer
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_valid", {15'd0, instr_valid_o}, 16'd1);
         chk("bp_instr", instr_o, 16'hA5A5);
         chk("bp_req",   {15'd0, mem_req_o}, 16'd0);
      end
      instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
      chk("bp_req_next", {15'd0, mem_req_o}, 16'd1);
      chk("bp_addr",     mem_addr_o, 16'h0001);

      // Ack delayed three cycles
      step(); step(); step();
      chk("st_hold_addr", mem_addr_o, 16'h0001);
      mem_ack_i = 1'b1; mem_rdata_i = 16'h1234;
      step();
      mem_ack_i = 1'b0;
      chk("st_cnt",   stall_cnt_o, EXP_STALL3);
      chk("st_instr", instr_o, 16'h1234);
      chk("st_pc",    pc_o, 16'h0002);

      // Redirect in the ack cycle drops the data
      instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
      mem_ack_i = 1'b1; mem_rdata_i = 16'hDEAD; redirect_i = 1'b1; redirect_pc_i = 16'h0040;
      step();
      mem_ack_i = 1'b0; redirect_i = 1'b0;
      chk("rd_valid", {15'd0, instr_valid_o}, 16'd0);
      chk("rd_req",   {15'd0, mem_req_o}, 16'd1);
      chk("rd_addr",  mem_addr_o, 16'h0040);

      // Redirect in VALID beats a simultaneous transfer
      mem_ack_i = 1'b1; mem_rdata_i = 16'hBEEF;
      step();
      mem_ack_i = 1'b0;
      chk("rv_instr", instr_o, 16'hBEEF);
      instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'hFFFF;
      step();
      instr_ready_i = 1'b0; redirect_i = 1'b0;
      chk("rv_valid", {15'd0, instr_valid_o}, 16'd0);
      chk("rv_addr",  mem_addr_o, 16'hFFFF);

      // PC wrap
      mem_ack_i = 1'b1; mem_rdata_i = 16'hC0DE;
      step();
      mem_ack_i = 1'b0;
      chk("wrap_pc",    pc_o, 16'h0000);
      chk("wrap_instr", instr_o, 16'hC0DE);

      // Park in IDLE, stray ack ignored, redirect while idle
      run_i = 1'b0; instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
      chk("idle_req", {15'd0, mem_req_o}, 16'd0);
      mem_ack_i = 1'b1; mem_rdata_i = 16'h7777;
      step();
      mem_ack_i = 1'b0;
      chk("idle_ack_valid", {15'd0, instr_valid_o}, 16'd0);
      chk("idle_ack_pc",    pc_o, 16'h0000);
      redirect_i = 1'b1; redirect_pc_i = 16'h1234;
      step();
      redirect_i = 1'b0;
      chk("idle_rd_pc",  pc_o, 16'h1234);
      chk("idle_rd_req", {15'd0, mem_req_o}, 16'd0);
      run_i = 1'b1;
      step();
      chk("resume_addr", mem_addr_o, 16'h1234);

      // Asynchronous reset during an outstanding request
      #2 reset = 1'b0;
      #1;
      chk("ar_req", {15'd0, mem_req_o}, 16'd0);
      chk("ar_pc",  pc_o, RPC);
      step();
      reset = 1'b1;
      step();
      chk("ar_restart_req",  {15'd0, mem_req_o}, 16'd1);
      chk("ar_restart_addr", mem_addr_o, RPC);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-low reset (asserted when 0).
REQ-004 Port run_i  input  1  SHALL enable fetching; low parks the unit in IDLE at the next permitted point.
REQ-005 Port redirect_i  input  1  SHALL request a PC change (branch/jump) this cycle.
REQ-006 Port redirect_pc_i  input  16  SHALL be the new fetch address, sampled when redirect_i=1.
REQ-007 Port mem_req_o  output  1  SHALL be the instruction-memory request strobe.
REQ-008 Port mem_addr_o  output  16  SHALL be the word address of the outstanding request (equals pc_o).
REQ-009 Port mem_ack_i  input  1  SHALL indicate mem_rdata_i is valid and completes the request.
REQ-010 Port mem_rdata_i  input  16  SHALL be the returned instruction word.
REQ-011 Port instr_o  output  16  SHALL be the buffered instruction presented to the instruction register.
REQ-012 Port instr_valid_o  output  1  SHALL mark instr_o valid.
REQ-013 Port instr_ready_i  input  1  SHALL be the downstream load enable; transfer occurs when instr_valid_o and instr_ready_i are both 1.
REQ-014 Port pc_o  output  16  SHALL be the current fetch PC.
REQ-015 Port stall_cnt_o  output  16  SHALL be the memory-stall cycle count (see Configuration).

Function
REQ-016 FSM SHALL have exactly three states: IDLE, REQ, VALID.
REQ-017 IDLE: mem_req_o=0, instr_valid_o=0; go to REQ on the next edge when run_i=1.
REQ-018 REQ: mem_req_o=1, held high with stable mem_addr_o until mem_ack_i=1; run_i is ignored in REQ.
REQ-019 REQ with mem_ack_i=1: capture mem_rdata_i into instr_o, pc <= pc+1, go to VALID; instr_valid_o SHALL rise the cycle after ack (1-cycle latency).
REQ-020 PC increment SHALL be modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-021 VALID: instr_valid_o=1, instr_o stable until transfer; on transfer go to REQ if run_i=1, else IDLE.
REQ-022 redirect_i SHALL have priority over every other event: pc <= redirect_pc_i on that edge.
REQ-023 Redirect in REQ (with or without ack that cycle): returned data discarded, pc not incremented, remain in REQ, new address driven next cycle.
REQ-024 Redirect in VALID: buffered instruction discarded (instr_valid_o=0 next cycle) even if instr_ready_i=1 that cycle, go to REQ.
REQ-025 Redirect in IDLE: load pc, remain in IDLE.
REQ-026 mem_ack_i outside REQ SHALL be ignored.

Reset
REQ-027 reset=0 SHALL immediately force: state IDLE, pc_o=RESET_PC, instr_o=16'h0000, instr_valid_o=0, mem_req_o=0, stall_cnt_o=16'h0000.
REQ-028 Reset mid-transaction SHALL abandon the request without waiting for ack; first edge after release behaves per IDLE.

Configuration
REQ-029 Macro FETCH_STALL_CNT_EN defined: stall_cnt_o SHALL increment on every cycle in REQ with mem_ack_i=0, saturating at 16'hFFFF, cleared only by reset.
REQ-030 FETCH_STALL_CNT_EN undefined: counter logic SHALL be omitted and stall_cnt_o tied to 16'h0000; port list unchanged.

Verification
REQ-031 Reset release, run_i=1, ack same cycle as req with rdata=16'hA5A5 -> mem_addr_o=16'h0000, instr_valid_o=1 next cycle with instr_o=16'hA5A5, pc_o=16'h0001.
REQ-032 instr_ready_i=0 for 4 cycles in VALID -> instr_o/instr_valid_o held, mem_req_o=0; ready=1 -> mem_req_o=1 next cycle at addr 16'h0001.
REQ-033 ack delayed 3 cycles with FETCH_STALL_CNT_EN -> stall_cnt_o=3 after ack; without macro -> stall_cnt_o=0.
REQ-034 redirect_i=1, redirect_pc_i=16'h0040 in cycle with ack -> data dropped, no valid, next mem_addr_o=16'h0040.
REQ-035 PC=16'hFFFF fetch acked -> pc_o=16'h0000.
REQ-036 reset=0 asserted while mem_req_o=1 -> mem_req_o=0 and pc_o=RESET_PC without a clock edge.
